serial_mag_comparator: RTL
==========================

Name: serial_mag_comparator

Overview:
- Multi-cycle N-bit magnitude comparator built around the existing 2-bit comparator cell, which is instantiated outside this block.
- Operands are latched on start and presented to the cell 2 bits per cycle, MSB slice first, on slice_a/slice_b.
- The cell's g/e/l answer returns on cmp_g/cmp_e/cmp_l and is sampled the same cycle.
- Evaluation stops at the first decisive slice or after the last slice.
- The final gt/eq/lt result is held for downstream logic, with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand width in bits; must be even and >= 2. Slice count S = WIDTH/2.

Ports:
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk
- start  input  1  request a compare; accepted only in IDLE
- a  input  WIDTH  operand A, sampled at the accepting edge
- b  input  WIDTH  operand B, sampled at the accepting edge
- slice_a  output  2  current A slice to the 2-bit comparator
- slice_b  output  2  current B slice to the 2-bit comparator
- cmp_g  input  1  comparator: slice_a > slice_b
- cmp_e  input  1  comparator: slice_a == slice_b
- cmp_l  input  1  comparator: slice_a < slice_b
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- gt  output  1  held result A > B
- eq  output  1  held result A == B
- lt  output  1  held result A < B
- err  output  1  held; cmp inputs were not one-hot during the compare

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset (rst_n=0 at an edge) takes effect at any state, including mid-RUN:
  - state=IDLE, shift registers and slice counter cleared;
  - slice_a=slice_b=0, busy=0, done=0, gt=eq=lt=0, err=0.
  - The in-flight compare is discarded; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE:
  - slice_a=slice_b=2'b00.
  - With start=1 at an edge: load a_sh<=a, b_sh<=b, cnt<=0, clear gt/eq/lt/err, go to RUN.
- RUN:
  - slice_a=a_sh[WIDTH-1:WIDTH-2] and slice_b=b_sh[WIDTH-1:WIDTH-2], driven from registers only (no combinational path from cmp_* to slice_*).
  - At each edge, sample cmp_g/cmp_e/cmp_l:
    - not exactly one high: err<=1, gt/eq/lt<=0, go to DONE;
    - cmp_g=1: gt<=1, go to DONE;
    - cmp_l=1: lt<=1, go to DONE;
    - cmp_e=1 and cnt==S-1: eq<=1, go to DONE;
    - cmp_e=1 otherwise: a_sh, b_sh shift left by 2 (zero fill), cnt<=cnt+1, stay in RUN.
- DONE:
  - done=1 for exactly this one cycle; slice_a=slice_b=0; next edge goes to IDLE unconditionally.
- Latency:
  - If start is accepted at edge k and s slices are examined (1 <= s <= S), the result registers update at edge k+s.
  - done is high in the cycle following edge k+s; busy falls after edge k+s+1.
  - Earliest next accept is edge k+s+2.
- start while busy (RUN or DONE) is ignored: operands are not re-latched and there is no queueing.
- Result hold:
  - gt/eq/lt/err keep their values through IDLE until the next accepted start, which clears them at the accepting edge.
  - After any done, exactly one of gt/eq/lt is high, or err=1 with all three low.
- cnt width is clog2(S) with a minimum of 1 bit; cnt never exceeds S-1.
- Operand changes on a/b after acceptance have no effect.

Test Plan:
Use WIDTH=8 with a behavioural 2-bit comparator on slice/cmp for scenarios 1-5.
1. Equal operands: start with a=8'hA5, b=8'hA5 -> slices 10/10, 10/10, 01/01, 01/01 on 4 consecutive RUN cycles; done 4 cycles after accept; eq=1, gt=lt=0.
2. Early-exit greater: a=8'hC0, b=8'h40 -> first slice 11 vs 01 gives gt; done in the cycle after edge k+1; gt=1; only one slice presented.
3. Last-slice less: a=8'h12, b=8'h13 -> 4 slices, final 10 vs 11; lt=1; results held through 10 idle cycles until next start.
4. start held high throughout scenario 1 and a/b changed mid-RUN:
   - result still eq=1 and done pulses once;
   - the following accept occurs at edge k+s+2 with the new operands.
5. rst_n=0 for one edge during the 2nd RUN cycle of a=8'h00, b=8'h00:
   - next cycle IDLE, all outputs 0, no done pulse;
   - a new compare afterwards completes normally.
6. Protocol error: the bench drives cmp_g=cmp_l=1 on the first slice -> err=1, gt=eq=lt=0, done pulses after 1 slice; next accepted start clears err.

Source files
------------

// File: rtl/serial_mag_comparator_if.sv
// Bundle of the serial magnitude comparator's request/result signals and its
// link to the external 2-bit comparator cell.
//   start, a, b            : compare request and operands (into the comparator)
//   slice_a, slice_b       : current 2-bit slices sent to the comparator cell
//   cmp_g, cmp_e, cmp_l    : cell answer for the current slices
//   busy, done             : activity flag and one-cycle completion pulse
//   gt, eq, lt, err        : held result of the last compare
// Modport slave is the comparator block; master is the surrounding logic
// (requester plus the 2-bit cell).
interface serial_mag_comparator_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       slice_a;
    logic [1:0]       slice_b;
    logic             cmp_g;
    logic             cmp_e;
    logic             cmp_l;
    logic             busy;
    logic             done;
    logic             gt;
    logic             eq;
    logic             lt;
    logic             err;

    modport slave (
        input  start, a, b, cmp_g, cmp_e, cmp_l,
        output slice_a, slice_b, busy, done, gt, eq, lt, err
    );

    modport master (
        output start, a, b, cmp_g, cmp_e, cmp_l,
        input  slice_a, slice_b, busy, done, gt, eq, lt, err
    );
endinterface

// File: rtl/serial_mag_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator. Operands are latched on start
// and fed MSB-slice first, 2 bits per cycle, to an external 2-bit comparator
// cell; evaluation stops at the first decisive slice or after the last one.
// Ports:
//   clk    : clock, all state changes on the rising edge
//   rst_n  : synchronous active-low reset
//   bus    : serial_mag_comparator_if.slave (request, cell link, result)
//
// state   | meaning
// --------+------------------------------------------------------------
// ST_IDLE | waiting for start; result registers hold the last answer
// ST_RUN  | presenting slice cnt, sampling the cell answer every edge
// ST_DONE | one-cycle done pulse, then back to idle
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    serial_mag_comparator_if.slave bus
);
    localparam int S     = WIDTH / 2;
    localparam int CNT_W = (S > 1) ? $clog2(S) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(S - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [CNT_W-1:0] r_cnt;
    logic             r_gt;
    logic             r_eq;
    logic             r_lt;
    logic             r_err;

    logic             w_onehot;
    logic             w_load;
    logic             w_shift;
    logic             w_set_gt;
    logic             w_set_eq;
    logic             w_set_lt;
    logic             w_set_err;

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_set_gt    = 1'b0;
        w_set_eq    = 1'b0;
        w_set_lt    = 1'b0;
        w_set_err   = 1'b0;
        bus.slice_a = 2'b00;
        bus.slice_b = 2'b00;
        bus.done    = 1'b0;

        case ({bus.cmp_g, bus.cmp_e, bus.cmp_l})
            3'b100, 3'b010, 3'b001: w_onehot = 1'b1;
            default:                w_onehot = 1'b0;
        endcase

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // Slices come straight from the shift registers so the cell
                // answer never feeds back into what is presented to it.
                bus.slice_a = r_a_sh[WIDTH-1 -: 2];
                bus.slice_b = r_b_sh[WIDTH-1 -: 2];
                if (!w_onehot) begin
                    w_set_err   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (bus.cmp_g) begin
                    w_set_gt    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (bus.cmp_l) begin
                    w_set_lt    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_set_eq    = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_shift     = 1'b1;
                end
            end
            ST_DONE: begin
                bus.done    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_cnt  <= '0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
            r_err  <= 1'b0;
        end else if (w_load) begin
            r_a_sh <= bus.a;
            r_b_sh <= bus.b;
            r_cnt  <= '0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (w_shift) begin
                r_a_sh <= r_a_sh << 2;
                r_b_sh <= r_b_sh << 2;
                r_cnt  <= r_cnt + 1'b1;
            end
            if (w_set_gt)  r_gt  <= 1'b1;
            if (w_set_eq)  r_eq  <= 1'b1;
            if (w_set_lt)  r_lt  <= 1'b1;
            if (w_set_err) begin
                r_err <= 1'b1;
                r_gt  <= 1'b0;
                r_eq  <= 1'b0;
                r_lt  <= 1'b0;
            end
        end
    end

    assign bus.busy = (r_state != ST_IDLE);
    assign bus.gt   = r_gt;
    assign bus.eq   = r_eq;
    assign bus.lt   = r_lt;
    assign bus.err  = r_err;
endmodule
